// File: rtl/tapped_delay_block.sv
// One FIR tap: registered sample delay plus a zero-latency multiply-accumulate.
// Define TDB_SATURATE_EN to clamp y_out on overflow instead of wrapping.
module tapped_delay_block #(
    parameter int N    = 32,
    parameter int FRAC = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic signed [N-1:0] b,
    input  logic signed [N-1:0] x_in,
    output logic signed [N-1:0] x_out,
    input  logic signed [N-1:0] y_in,
    output logic signed [N-1:0] y_out
);

`ifdef TDB_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic signed [N-1:0]   r_x;
    logic signed [2*N-1:0] w_prod;
    logic signed [2*N-1:0] w_shift;
    logic signed [2*N:0]   w_sum;
    logic                  w_overflow;
    logic signed [N-1:0]   w_clamp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x <= '0;
        end else if (ena) begin
            r_x <= x_in;
        end
    end

    assign x_out = r_x;

    // Operands are sign-extended to 2N bits so the product is the full signed result.
    assign w_prod  = $signed({{N{b[N-1]}}, b}) * $signed({{N{x_in[N-1]}}, x_in});
    assign w_shift = w_prod >>> FRAC;
    assign w_sum   = {w_shift[2*N-1], w_shift} + {{(N+1){y_in[N-1]}}, y_in};

    // The sum fits in N bits only when its top N+2 bits are all copies of the sign.
    assign w_overflow = !((&w_sum[2*N:N-1]) || !(|w_sum[2*N:N-1]));
    assign w_clamp    = w_sum[2*N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};

    always_comb begin
        y_out = w_sum[N-1:0];
        if (SAT && w_overflow) begin
            y_out = w_clamp;
        end
    end

endmodule

// File: tb/tb_tapped_delay_block.sv
// Directed self-checking bench for tapped_delay_block: MAC table, delay/hold/reset
// sequences, an 8-bit overflow instance and a four-tap cascade impulse response.
module tb_tapped_delay_block;

    typedef struct {
        logic signed [31:0] b;
        logic signed [31:0] x;
        logic signed [31:0] y;
        logic signed [31:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    logic ena;
    logic signed [31:0] bIn;
    logic signed [31:0] xIn;
    logic signed [31:0] xOut;
    logic signed [31:0] yIn;
    logic signed [31:0] yOut;

    logic signed [7:0] b8;
    logic signed [7:0] x8;
    logic signed [7:0] xOut8;
    logic signed [7:0] y8;
    logic signed [7:0] yOut8;

    logic signed [31:0] tapX [0:4];
    logic signed [31:0] tapY [0:4];

    int total = 0;
    int bad = 0;

    vec_t vecs [7];
    int cascExp [5];

    tapped_delay_block #(.N(32), .FRAC(0)) dut (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .b     (bIn),
        .x_in  (xIn),
        .x_out (xOut),
        .y_in  (yIn),
        .y_out (yOut)
    );

    tapped_delay_block #(.N(8), .FRAC(0)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .b     (b8),
        .x_in  (x8),
        .x_out (xOut8),
        .y_in  (y8),
        .y_out (yOut8)
    );

    assign tapY[0] = '0;

    for (genvar k = 0; k < 4; k++) begin : gTap
        tapped_delay_block #(.N(32), .FRAC(0)) tap (
            .clk   (clk),
            .rst   (rst),
            .ena   (ena),
            .b     (32'(k + 1)),
            .x_in  (tapX[k]),
            .x_out (tapX[k+1]),
            .y_in  (tapY[k]),
            .y_out (tapY[k+1])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic signed [31:0] bv, input logic signed [31:0] xv,
                                 input logic signed [31:0] yv);
        bIn = bv;
        xIn = xv;
        yIn = yv;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic signed [31:0] act,
                               input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{b: 3,  x: -4,  y: 10, exp: -2};
        vecs[1] = '{b: 0,  x: 123, y: 5,  exp: 5};
        vecs[2] = '{b: -7, x: -8,  y: 0,  exp: 56};
        vecs[3] = '{b: 1,  x: -1,  y: -1, exp: -2};
`ifdef TDB_SATURATE_EN
        vecs[4] = '{b: 32'h7FFFFFFF, x: 2,  y: 0,  exp: 32'h7FFFFFFF};
        vecs[5] = '{b: 32'h80000000, x: 1,  y: -1, exp: 32'h80000000};
        vecs[6] = '{b: 32'h80000000, x: -1, y: 0,  exp: 32'h7FFFFFFF};
`else
        vecs[4] = '{b: 32'h7FFFFFFF, x: 2,  y: 0,  exp: -2};
        vecs[5] = '{b: 32'h80000000, x: 1,  y: -1, exp: 32'h7FFFFFFF};
        vecs[6] = '{b: 32'h80000000, x: -1, y: 0,  exp: 32'h80000000};
`endif
        cascExp = '{1, 2, 3, 4, 0};

        rst = 1'b0;
        ena = 1'b0;
        bIn = '0;
        xIn = '0;
        yIn = '0;
        b8 = '0;
        x8 = '0;
        y8 = '0;
        tapX[0] = '0;
        #1;
        checkOutput("resetState", xOut, 0);

        // The MAC path is combinational, so it is exercised while reset is still held.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].b, vecs[i].x, vecs[i].y);
            checkOutput($sformatf("mac[%0d]", i), yOut, vecs[i].exp);
        end

        b8 = 8'sd127;
        x8 = 8'sd127;
        y8 = 8'sd0;
        #1;
`ifdef TDB_SATURATE_EN
        checkOutput("ovfPos8", yOut8, 127);
`else
        checkOutput("ovfPos8", yOut8, 1);
`endif
        b8 = -8'sd128;
        y8 = -8'sd1;
        #1;
`ifdef TDB_SATURATE_EN
        checkOutput("ovfNeg8", yOut8, -128);
`else
        checkOutput("ovfNeg8", yOut8, 127);
`endif

        @(negedge clk);
        rst = 1'b1;
        ena = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            xIn = i;
            #1;
            checkOutput($sformatf("delay[%0d]", i), xOut, i - 1);
            @(negedge clk);
        end
        checkOutput("delayLast", xOut, 3);

        xIn = 5;
        @(negedge clk);
        checkOutput("holdLoad", xOut, 5);
        ena = 1'b0;
        xIn = 9;
        repeat (2) @(negedge clk);
        checkOutput("holdTwoEdges", xOut, 5);

        ena = 1'b1;
        xIn = 7;
        @(negedge clk);
        checkOutput("preResetLoad", xOut, 7);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("asyncReset", xOut, 0);
        @(negedge clk);
        checkOutput("resetHeld", xOut, 0);
        rst = 1'b1;
        xIn = 11;
        @(negedge clk);
        checkOutput("firstEdgeAfterReset", xOut, 11);

        // Impulse into the cascade; the chain output should replay the coefficients.
        for (int i = 0; i < 5; i++) begin
            tapX[0] = (i == 0) ? 32'sd1 : 32'sd0;
            #1;
            checkOutput($sformatf("cascade[%0d]", i), tapY[4], cascExp[i]);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
